// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 8;

   // Low len bits set; callers slice the result down to their pattern width.
   function automatic logic [31:0] len_mask(input int unsigned len);
      if (len >= 32)
         return '1;
      return (32'd1 << len) - 32'd1;
   endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config handshake, serial stream and status bundle of the pattern detector.
interface seq_detect_ctrl_if
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = DEF_CNT_W,
   localparam int LEN_W  = $clog2(MAX_LEN) + 1
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic [CNT_W-1:0]   cfg_target;
   logic               abort;
   logic               data_valid;
   logic               data_in;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      output abort, data_valid, data_in,
      input  cfg_ready, match, match_cnt, busy, done, err
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      input  abort, data_valid, data_in,
      output cfg_ready, match, match_cnt, busy, done, err
   );
endinterface

// File: rtl/seq_window_match.sv
// Shift window + fill counter; hit is combinational from the post-shift window and fill.
module seq_window_match
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               shift_en_i,
   input  logic               clear_i,
   input  logic               data_i,
   input  logic [LEN_W-1:0]   len_i,
   input  logic [MAX_LEN-1:0] pattern_i,
   input  logic               overlap_i,
   output logic               hit_o
);
   logic [MAX_LEN-1:0] win_q, win_d;
   logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
   logic [31:0]        mask_full;
   logic [MAX_LEN-1:0] mask;

   assign mask_full = len_mask(32'(len_i));
   assign mask      = mask_full[MAX_LEN-1:0];
   assign win_d     = {win_q[MAX_LEN-2:0], data_i};
   assign fill_inc  = (fill_q == len_i) ? len_i : fill_q + 1'b1;
   assign hit_o     = shift_en_i && (fill_inc == len_i) && (((win_d ^ pattern_i) & mask) == '0);

   // Non-overlap restarts the fill so bits of this match cannot seed the next one.
   assign fill_d = (hit_o && !overlap_i) ? '0 : fill_inc;

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         win_q  <= '0;
         fill_q <= '0;
      end else if (shift_en_i) begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detection controller: config handshake, scan, count, done.
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = DEF_CNT_W,
   localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   seq_detect_ctrl_if.slave bus
);
   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic [CNT_W-1:0]   target_q, target_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               match_q, match_d;
   logic               err_q, err_d;
   logic               clear, shift_en, hit, cfg_hs, cfg_bad;

   assign cfg_hs   = bus.cfg_valid && (state_q != ST_RUN);
   assign cfg_bad  = (bus.cfg_len == '0) || (int'(bus.cfg_len) > MAX_LEN);
   assign shift_en = (state_q == ST_RUN) && bus.data_valid && !bus.abort;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   seq_window_match #(.MAX_LEN(MAX_LEN)) u_win (
      .clk       (clk),
      .rst       (rst),
      .shift_en_i(shift_en),
      .clear_i   (clear),
      .data_i    (bus.data_in),
      .len_i     (len_q),
      .pattern_i (pattern_q),
      .overlap_i (overlap_q),
      .hit_o     (hit)
   );

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      target_d  = target_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      match_d   = 1'b0;
      clear     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (hit) begin
               match_d = 1'b1;
               cnt_d   = cnt_inc;
               if (target_q != '0 && cnt_inc == target_q)
                  state_d = ST_DONE;
            end
         end
         default: begin
            // A new config takes precedence over abort while idle or done.
            if (cfg_hs) begin
               pattern_d = bus.cfg_pattern;
               len_d     = bus.cfg_len;
               overlap_d = bus.cfg_overlap;
               target_d  = bus.cfg_target;
               cnt_d     = '0;
               clear     = 1'b1;
               err_d     = cfg_bad;
               state_d   = cfg_bad ? ST_DONE : ST_RUN;
            end else if (bus.abort) begin
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         target_q  <= '0;
         cnt_q     <= '0;
         match_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         target_q  <= target_d;
         cnt_q     <= cnt_d;
         match_q   <= match_d;
         err_q     <= err_d;
      end
   end

   assign bus.cfg_ready = (state_q != ST_RUN);
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.err       = err_q;
   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;
   import seq_detect_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();

   seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic [7:0] tgt, input logic dv);
      bus.cfg_valid   = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_overlap = ov;
      bus.cfg_target  = tgt;
      bus.data_valid  = dv;
      bus.data_in     = dv;
      tick();
      bus.cfg_valid  = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in    = 1'b0;
   endtask

   task automatic send(input logic b);
      bus.data_valid = 1'b1;
      bus.data_in    = b;
      tick();
      bus.data_valid = 1'b0;
      bus.data_in    = 1'b0;
   endtask

   task automatic do_abort();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic send_chk(input string tag, input logic b, input logic exp_match);
      send(b);
      check(tag, 32'(bus.match), 32'(exp_match));
   endtask

   initial begin
      rst = 1'b1;
      bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
      bus.cfg_overlap = 1'b0; bus.cfg_target = '0; bus.abort = 1'b0;
      bus.data_valid = 1'b0; bus.data_in = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_ready", 32'(bus.cfg_ready), 32'd1);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_err",   32'(bus.err), 32'd0);
      check("rst_match", 32'(bus.match), 32'd0);
      check("rst_cnt",   32'(bus.match_cnt), 32'd0);

      // Basic 110, non-overlap, free running
      cfg(8'b110, 4'd3, 1'b0, 8'd0, 1'b0);
      check("b110_busy",  32'(bus.busy), 32'd1);
      check("b110_ready", 32'(bus.cfg_ready), 32'd0);
      send_chk("b110_m1", 1'b1, 1'b0);
      send_chk("b110_m2", 1'b1, 1'b0);
      send_chk("b110_m3", 1'b0, 1'b1);
      send_chk("b110_m4", 1'b1, 1'b0);
      send_chk("b110_m5", 1'b1, 1'b0);
      send_chk("b110_m6", 1'b0, 1'b1);
      check("b110_cnt",  32'(bus.match_cnt), 32'd2);
      check("b110_done", 32'(bus.done), 32'd0);
      tick();
      check("b110_pulse", 32'(bus.match), 32'd0);
      do_abort();
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_cnt",  32'(bus.match_cnt), 32'd2);
      check("abort_done", 32'(bus.done), 32'd0);

      // Overlap: 11 in 1111 -> 3 matches
      cfg(8'b11, 4'd2, 1'b1, 8'd0, 1'b0);
      check("ov_cnt_clr", 32'(bus.match_cnt), 32'd0);
      send_chk("ov_m1", 1'b1, 1'b0);
      send_chk("ov_m2", 1'b1, 1'b1);
      send_chk("ov_m3", 1'b1, 1'b1);
      send_chk("ov_m4", 1'b1, 1'b1);
      check("ov_cnt", 32'(bus.match_cnt), 32'd3);
      do_abort();

      // Non-overlap: 11 in 1111 -> 2 matches
      cfg(8'b11, 4'd2, 1'b0, 8'd0, 1'b0);
      check("nov_cnt_clr", 32'(bus.match_cnt), 32'd0);
      send_chk("nov_m1", 1'b1, 1'b0);
      send_chk("nov_m2", 1'b1, 1'b1);
      send_chk("nov_m3", 1'b1, 1'b0);
      send_chk("nov_m4", 1'b1, 1'b1);
      check("nov_cnt", 32'(bus.match_cnt), 32'd2);
      do_abort();

      // Target stop: pattern 1, target 2, stream 1,0,1,1
      cfg(8'b1, 4'd1, 1'b0, 8'd2, 1'b0);
      send_chk("tgt_m1", 1'b1, 1'b1);
      check("tgt_cnt1", 32'(bus.match_cnt), 32'd1);
      send_chk("tgt_m2", 1'b0, 1'b0);
      send_chk("tgt_m3", 1'b1, 1'b1);
      check("tgt_done",  32'(bus.done), 32'd1);
      check("tgt_busy",  32'(bus.busy), 32'd0);
      check("tgt_cnt2",  32'(bus.match_cnt), 32'd2);
      check("tgt_ready", 32'(bus.cfg_ready), 32'd1);
      send_chk("tgt_m4", 1'b1, 1'b0);
      check("tgt_hold", 32'(bus.match_cnt), 32'd2);
      check("tgt_done2", 32'(bus.done), 32'd1);

      // Illegal length 0 from DONE, then abort clears done/err
      cfg(8'b0, 4'd0, 1'b0, 8'd0, 1'b0);
      check("ill0_done", 32'(bus.done), 32'd1);
      check("ill0_err",  32'(bus.err), 32'd1);
      check("ill0_busy", 32'(bus.busy), 32'd0);
      do_abort();
      check("ill0_abort_done", 32'(bus.done), 32'd0);
      check("ill0_abort_err",  32'(bus.err), 32'd0);

      // Illegal length MAX_LEN+1, then a legal config clears both
      cfg(8'hFF, 4'd9, 1'b0, 8'd0, 1'b0);
      check("ill9_done", 32'(bus.done), 32'd1);
      check("ill9_err",  32'(bus.err), 32'd1);
      check("ill9_busy", 32'(bus.busy), 32'd0);

      // Legal config with a data bit in the handshake cycle (ignored); abort priority
      cfg(8'b110, 4'd3, 1'b0, 8'd0, 1'b1);
      check("fix_done", 32'(bus.done), 32'd0);
      check("fix_err",  32'(bus.err), 32'd0);
      check("fix_busy", 32'(bus.busy), 32'd1);
      check("hs_bit_ign", 32'(bus.match_cnt), 32'd0);
      send_chk("ab_m1", 1'b1, 1'b0);
      send_chk("ab_m2", 1'b1, 1'b0);
      send_chk("ab_m3", 1'b0, 1'b1);
      send_chk("ab_m4", 1'b1, 1'b0);
      send_chk("ab_m5", 1'b1, 1'b0);
      bus.abort = 1'b1; bus.data_valid = 1'b1; bus.data_in = 1'b0;
      tick();
      bus.abort = 1'b0; bus.data_valid = 1'b0;
      check("ab_match", 32'(bus.match), 32'd0);
      check("ab_busy",  32'(bus.busy), 32'd0);
      check("ab_ready", 32'(bus.cfg_ready), 32'd1);
      check("ab_cnt",   32'(bus.match_cnt), 32'd1);
      send_chk("idle_ign", 1'b0, 1'b0);
      check("idle_cnt", 32'(bus.match_cnt), 32'd1);

      // Counter saturation: 256 overlapping single-bit hits
      cfg(8'b1, 4'd1, 1'b1, 8'd0, 1'b0);
      for (int i = 0; i < 256; i++) send(1'b1);
      check("sat_cnt",   32'(bus.match_cnt), 32'd255);
      check("sat_match", 32'(bus.match), 32'd1);
      do_abort();

      // Reset mid-run with match_cnt=5
      cfg(8'b1, 4'd1, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 5; i++) send(1'b1);
      check("mid_cnt5", 32'(bus.match_cnt), 32'd5);
      rst = 1'b1; bus.data_valid = 1'b1; bus.data_in = 1'b1;
      tick();
      rst = 1'b0; bus.data_valid = 1'b0; bus.data_in = 1'b0;
      check("mid_ready", 32'(bus.cfg_ready), 32'd1);
      check("mid_busy",  32'(bus.busy), 32'd0);
      check("mid_done",  32'(bus.done), 32'd0);
      check("mid_err",   32'(bus.err), 32'd0);
      check("mid_match", 32'(bus.match), 32'd0);
      check("mid_cnt",   32'(bus.match_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern detection controller that generalises the team's fixed 110 Moore detector. It accepts a configuration (pattern, length, overlap mode, target match count) through a valid/ready handshake. It then scans a qualified serial bit stream, counts matches and reports completion. It sits between the test/control logic and the serial data source, and replaces hard-coded per-pattern detector FSMs.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: width of match counter and target.
- LEN_W, $clog2(MAX_LEN)+1: width of cfg_len (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_target  in  CNT_W  matches until done; 0 = run until abort.
- abort  in  1  stop scanning and return to IDLE.
- data_valid  in  1  data_in qualified this cycle.
- data_in  in  1  serial bit.
- match  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  matches since last accepted config.
- busy  out  1  in RUN.
- done  out  1  target reached or config error; held until next config.
- err  out  1  last config had illegal cfg_len; held with done.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE.** cfg_ready=1. A handshake (cfg_valid&cfg_ready) latches all cfg_* fields, clears the window, clears fill and match_cnt, clears done/err, and moves to RUN.
  - If cfg_len is 0 or greater than MAX_LEN, the state moves to DONE instead, with done=1 and err=1.
- **RUN.** busy=1, cfg_ready=0, so cfg_valid is ignored. On each data_valid:
  - data_in shifts into the window LSB.
  - fill_next = min(fill+1, len).
  - A hit occurs when fill_next==len and the low len bits of the window equal the low len bits of the pattern.
- **On a hit:**
  - match pulses.
  - match_cnt increments, saturating at all-ones.
  - Non-overlap mode: fill is cleared to 0, so prior bits cannot contribute to the next match.
  - Overlap mode: fill stays at len.
- **Target reached.** If target≠0 and the incremented match_cnt equals target, the state moves to DONE.
- **abort in RUN.** The state moves to IDLE and the bit offered in that cycle is discarded (no hit). match_cnt is retained, done stays 0.
- **DONE.** done=1, busy=0, cfg_ready=1, and match_cnt is held. A new handshake behaves exactly as from IDLE. abort in DONE moves to IDLE and clears done/err.
- **data_valid outside RUN** is ignored.

## Timing
- **Reset values:** state IDLE, cfg_ready=1, busy=0, done=0, err=0, match=0, match_cnt=0. Window and fill are cleared.
- **Outputs are registered.** match, match_cnt, busy and done update one cycle after the clk edge that samples the bit or handshake.
- **Config to RUN:** busy=1 in the cycle after the handshake. A data_valid bit in the handshake cycle itself is ignored.
- **Final match:** the final match and done rise in the same cycle, with match_cnt==target. busy falls in that same cycle.
- **Back-to-back bits:** one bit per cycle at full rate, no stall.
- **Simultaneous events:** abort beats data_valid. rst beats everything.
- **Reset mid-RUN:** immediate return to reset values at the next edge.

## Structure
- Package seq_detect_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DONE);
  - the default MAX_LEN/CNT_W constants;
  - a helper that computes the length mask from cfg_len.
- Sub-module seq_window_match holds the shift window, fill counter, masked compare and overlap clear. It has inputs shift_en, clear, len, pattern, overlap and output hit (combinational from next-state values).
- seq_detect_ctrl holds the FSM, config registers, counter and output registers.

## Test plan
- **Basic 110 detection.** pattern=3'b110, len=3, overlap=0, target=0; stream 1,1,0,1,1,0 -> match pulses after the 3rd and 6th bits; match_cnt=2; done=0.
- **Overlap vs non-overlap.** pattern=2'b11, len=2; stream 1,1,1,1.
  - overlap=1 -> 3 matches.
  - overlap=0 -> 2 matches.
- **Target stop.** pattern=1'b1, len=1, target=2; stream 1,0,1,1 -> done=1 and match_cnt=2 after the 3rd bit; the 4th bit is ignored; cfg_ready=1.
- **Abort priority.** In RUN with 2 of 3 pattern bits received, assert abort together with the completing bit -> no match; state IDLE; match_cnt unchanged.
- **Illegal config.** cfg_len=0 (also MAX_LEN+1) -> the cycle after the handshake: done=1, err=1, busy=0; a subsequent valid config clears both.
- **Reset mid-run.** Assert rst for one cycle during RUN with match_cnt=5 -> all outputs at reset values the next cycle; cfg_ready=1.
